uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/uart_cmd_parser_if.sv | 31 +++
 rtl/cmd_gap_timer.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and byte classifiers for the UART command parser.
package uart_cmd_pkg;

   // Frame characters
   localparam logic [7:0] CH_LPAR = 8'h28;
   localparam logic [7:0] CH_RPAR = 8'h29;
   localparam logic [7:0] CH_HASH = 8'h23;
   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_A    = 8'h41;
   localparam logic [7:0] CH_Z    = 8'h5A;

   // Drop causes reported on err_code
   localparam logic [1:0] ERR_SYNTAX = 2'd0;
   localparam logic [1:0] ERR_OVF    = 2'd1;
   localparam logic [1:0] ERR_TMO    = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GET_ID  = 2'd1,
      ST_GET_DIG = 2'd2,
      ST_GET_END = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CH_0) && (b <= CH_9);
   endfunction

   function automatic logic is_upper(input logic [7:0] b);
      return (b >= CH_A) && (b <= CH_Z);
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle between the UART receiver side and the parser.
//
// Handshake: there is no ready. rx_valid is a one-cycle strobe and the
// parser consumes rx_data in every cycle rx_valid is high, including
// back-to-back cycles. cmd_valid and err_pulse are one-cycle strobes with no
// back-pressure; cmd_id/cmd_arg/err_code/frame_cnt hold their value between
// strobes. dbg_state exposes the parser FSM state for observation.
interface uart_cmd_parser_if;
   import uart_cmd_pkg::*;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_valid;
   logic [7:0] cmd_id;
   logic [7:0] cmd_arg;
   logic       err_pulse;
   logic [1:0] err_code;
   logic [7:0] frame_cnt;
   state_t     dbg_state;

   modport master (
      output rx_data, rx_valid,
      input  cmd_valid, cmd_id, cmd_arg, err_pulse, err_code, frame_cnt, dbg_state
   );

   modport slave (
      input  rx_data, rx_valid,
      output cmd_valid, cmd_id, cmd_arg, err_pulse, err_code, frame_cnt, dbg_state
   );

endinterface

// File: rtl/cmd_gap_timer.sv
// Inter-byte gap timer. The register holds the cycles remaining before
// expiry; reset and clear load the full budget, i.e. zero cycles elapsed.
// expire_o is high in the cycle the budget is used up (CYCLES-1 cycles
// elapsed since the last clear) unless a clear arrives in that same cycle.
module cmd_gap_timer #(
   parameter int unsigned CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: reload on clear, otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = LOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes "(" ID digits ")" "#" command frames from the UART byte stream and
// publishes the ID and 8-bit argument of each good frame; drops and reports
// malformed, oversized or stalled frames.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_cmd_parser_if.slave bus
);

   state_t      state_q, state_d;
   logic [7:0]  id_q, id_d;
   logic [9:0]  acc_q, acc_d;
   logic [1:0]  dig_cnt_q, dig_cnt_d;
   logic [7:0]  cmd_id_q, cmd_id_d;
   logic [7:0]  cmd_arg_q, cmd_arg_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        err_pulse_q, err_pulse_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;

   logic        tmr_clr, tmr_en, tmr_expire;
   logic [11:0] acc_next;

   // Timer runs only inside a frame and restarts on every received byte
   assign tmr_clr = bus.rx_valid || (state_q == ST_IDLE);
   assign tmr_en  = (state_q != ST_IDLE);

   cmd_gap_timer #(
      .CYCLES (TIMEOUT_CYC)
   ) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   // Wide enough that 255*10+9 cannot wrap back below the 255 limit
   assign acc_next = ({2'b00, acc_q} * 12'd10) + {8'h00, bus.rx_data[3:0]};

   // Frame parser: next state, partial-frame fields and result strobes
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      acc_d       = acc_q;
      dig_cnt_d   = dig_cnt_q;
      cmd_id_d    = cmd_id_q;
      cmd_arg_d   = cmd_arg_q;
      cmd_valid_d = 1'b0;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      frame_cnt_d = frame_cnt_q;

      if (bus.rx_valid) begin
         if ((state_q != ST_IDLE) && (bus.rx_data == CH_LPAR)) begin
            // A fresh "(" mid-frame drops the old frame and starts a new one
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SYNTAX;
            acc_d       = '0;
            dig_cnt_d   = '0;
            state_d     = ST_GET_ID;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (bus.rx_data == CH_LPAR) begin
                     state_d = ST_GET_ID;
                  end
               end
               ST_GET_ID: begin
                  if (is_upper(bus.rx_data)) begin
                     id_d      = bus.rx_data;
                     acc_d     = '0;
                     dig_cnt_d = '0;
                     state_d   = ST_GET_DIG;
                  end else begin
                     err_pulse_d = 1'b1;
                     err_code_d  = ERR_SYNTAX;
                     state_d     = ST_IDLE;
                  end
               end
               ST_GET_DIG: begin
                  if (is_digit(bus.rx_data)) begin
                     if ((dig_cnt_q == 2'd3) || (acc_next > 12'd255)) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_OVF;
                        state_d     = ST_IDLE;
                     end else begin
                        acc_d     = acc_next[9:0];
                        dig_cnt_d = dig_cnt_q + 2'd1;
                     end
                  end else if ((bus.rx_data == CH_RPAR) && (dig_cnt_q != 2'd0)) begin
                     state_d = ST_GET_END;
                  end else begin
                     err_pulse_d = 1'b1;
                     err_code_d  = ERR_SYNTAX;
                     state_d     = ST_IDLE;
                  end
               end
               ST_GET_END: begin
                  if (bus.rx_data == CH_HASH) begin
                     cmd_valid_d = 1'b1;
                     cmd_id_d    = id_q;
                     cmd_arg_d   = acc_q[7:0];
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end else begin
                     err_pulse_d = 1'b1;
                     err_code_d  = ERR_SYNTAX;
                  end
                  state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end else if (tmr_expire) begin
         // Stalled frame; a byte in the expiry cycle takes priority above
         err_pulse_d = 1'b1;
         err_code_d  = ERR_TMO;
         state_d     = ST_IDLE;
      end
   end

   // State and output registers; reset discards any partial frame silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         id_q        <= 8'h00;
         acc_q       <= '0;
         dig_cnt_q   <= '0;
         cmd_id_q    <= 8'h00;
         cmd_arg_q   <= 8'h00;
         cmd_valid_q <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= ERR_SYNTAX;
         frame_cnt_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         acc_q       <= acc_d;
         dig_cnt_q   <= dig_cnt_d;
         cmd_id_q    <= cmd_id_d;
         cmd_arg_q   <= cmd_arg_d;
         cmd_valid_q <= cmd_valid_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_id    = cmd_id_q;
   assign bus.cmd_arg   = cmd_arg_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_code  = err_code_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames plus randomized traffic, all
// checked cycle by cycle against a grammar-level reference model.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int TMO = 16;

   logic clk;
   logic rst_n;

   uart_cmd_parser_if bus ();

   uart_cmd_parser #(
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Frame-level view: are we inside a frame, have we seen the ID letter,
   // how many digits / what value so far, have we seen ")".
   bit         m_in, m_have_id, m_rpar;
   int         m_ndig, m_val, m_gap;
   logic [7:0] m_id;
   bit         m_cmd_valid, m_err_pulse;
   logic [7:0] m_cmd_id, m_cmd_arg, m_frame_cnt;
   logic [1:0] m_err_code;

   task automatic model_reset();
      m_in = 0; m_have_id = 0; m_rpar = 0; m_ndig = 0; m_val = 0; m_gap = 0;
      m_id = 8'h00; m_cmd_valid = 0; m_err_pulse = 0;
      m_cmd_id = 8'h00; m_cmd_arg = 8'h00; m_frame_cnt = 8'h00; m_err_code = 2'd0;
   endtask

   task automatic model_drop(input logic [1:0] code);
      m_err_pulse = 1;
      m_err_code  = code;
      m_in        = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] b);
      m_cmd_valid = 0;
      m_err_pulse = 0;
      if (v) begin
         m_gap = 0;
         if (!m_in) begin
            if (b == CH_LPAR) begin m_in = 1; m_have_id = 0; end
         end else if (b == CH_LPAR) begin
            model_drop(ERR_SYNTAX);
            m_in = 1; m_have_id = 0;
         end else if (!m_have_id) begin
            if (b >= CH_A && b <= CH_Z) begin
               m_id = b; m_have_id = 1; m_ndig = 0; m_val = 0; m_rpar = 0;
            end else model_drop(ERR_SYNTAX);
         end else if (!m_rpar) begin
            if (b >= CH_0 && b <= CH_9) begin
               m_ndig++;
               m_val = m_val * 10 + (int'(b) - 48);
               if (m_ndig > 3 || m_val > 255) model_drop(ERR_OVF);
            end else if (b == CH_RPAR && m_ndig > 0) m_rpar = 1;
            else model_drop(ERR_SYNTAX);
         end else if (b == CH_HASH) begin
            m_cmd_valid = 1;
            m_cmd_id    = m_id;
            m_cmd_arg   = 8'(m_val);
            m_frame_cnt = m_frame_cnt + 8'd1;
            m_in        = 0;
            exp_q.push_back({m_cmd_id, m_cmd_arg});
         end else model_drop(ERR_SYNTAX);
      end else if (m_in) begin
         m_gap++;
         if (m_gap >= TMO) model_drop(ERR_TMO);
      end
   endtask

   task automatic compare_outputs();
      logic [15:0] e;
      chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_cmd_valid));
      chk("err_pulse", 32'(bus.err_pulse), 32'(m_err_pulse));
      chk("cmd_id",    32'(bus.cmd_id),    32'(m_cmd_id));
      chk("cmd_arg",   32'(bus.cmd_arg),   32'(m_cmd_arg));
      chk("err_code",  32'(bus.err_code),  32'(m_err_code));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_frame_cnt));
      chk("in_frame",  32'(bus.dbg_state != ST_IDLE), 32'(m_in));
      if (bus.cmd_valid === 1'b1) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_cmd", 32'({bus.cmd_id, bus.cmd_arg}), 32'(e));
         end else begin
            chk("sb_unexpected_cmd", 32'(bus.cmd_valid), 32'd0);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit v, input logic [7:0] b);
      @(negedge clk);
      bus.rx_valid = v;
      bus.rx_data  = v ? b : 8'($urandom);
      model_step(v, b);
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic send_str(input string s, input int max_gap);
      for (int i = 0; i < s.len(); i++) begin
         step(1'b1, s[i]);
         if (max_gap > 0 && i != s.len() - 1) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.rx_valid = 1'b0;
      model_reset();
      exp_q.delete();
      #1;
      compare_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      string s;
      logic [7:0] id;
      int arg;

      rst_n = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_outputs();
      chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Basic good frame, back-to-back bytes
      send_str("(M123)#", 0);
      chk("m123_valid", 32'(bus.cmd_valid), 32'd1);
      chk("m123_id",    32'(bus.cmd_id),    32'h4D);
      chk("m123_arg",   32'(bus.cmd_arg),   32'd123);
      chk("m123_cnt",   32'(bus.frame_cnt), 32'd1);

      // Overflow by value and by digit count
      send_str("(S256)#", 0);
      send_str("(S0042)#", 0);
      chk("ovf_code",     32'(bus.err_code), 32'(ERR_OVF));
      chk("ovf_keep_arg", 32'(bus.cmd_arg),  32'd123);

      // Resync on a second "("
      send_str("(M1(B7)#", 0);
      chk("resync_id",  32'(bus.cmd_id),  32'h42);
      chk("resync_arg", 32'(bus.cmd_arg), 32'd7);

      // Syntax errors and junk in IDLE; leading zeros
      send_str("(M)#", 0);
      send_str("(m5)#", 0);
      send_str("(M5)X", 0);
      chk("syn_code", 32'(bus.err_code), 32'(ERR_SYNTAX));
      send_str("AB#)", 0);
      send_str("(M007)#", 1);
      chk("lead0_arg", 32'(bus.cmd_arg), 32'd7);

      // Timeout exactly at expiry, then a byte landing on the expiry cycle
      send_str("(M5", 0);
      idle(TMO - 1);
      chk("pre_tmo_pulse", 32'(bus.err_pulse), 32'd0);
      idle(1);
      chk("tmo_pulse", 32'(bus.err_pulse), 32'd1);
      chk("tmo_code",  32'(bus.err_code),  32'(ERR_TMO));
      send_str("(M5", 0);
      idle(TMO - 1);
      step(1'b1, CH_RPAR);
      chk("byte_wins", 32'(bus.err_pulse), 32'd0);
      step(1'b1, CH_HASH);
      chk("byte_wins_arg", 32'(bus.cmd_arg), 32'd5);

      // Reset mid-frame
      send_str("(M12", 0);
      async_reset();
      chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
      send_str("(B9)#", 0);
      chk("post_rst_id",  32'(bus.cmd_id),  32'h42);
      chk("post_rst_arg", 32'(bus.cmd_arg), 32'd9);

      // 255 more good frames: counter wraps to 0
      for (int n = 0; n < 255; n++) begin
         id  = 8'($urandom_range(32'h41, 32'h5A));
         arg = $urandom_range(0, 255);
         s = $sformatf("(%c%0d)#", id, arg);
         send_str(s, $urandom_range(0, 1));
      end
      chk("cnt_wrap", 32'(bus.frame_cnt), 32'd0);

      // Randomized mixed traffic with corruption and occasional stalls
      for (int n = 0; n < 300; n++) begin
         int nd;
         id = ($urandom_range(0, 15) == 0) ? 8'h6D : 8'($urandom_range(32'h41, 32'h5A));
         nd = $urandom_range(0, 4);
         s = $sformatf("(%c", id);
         for (int k = 0; k < nd; k++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
         s = {s, ")#"};
         if ($urandom_range(0, 7) == 0) begin
            int pos;
            logic [7:0] junk;
            logic [7:0] pool [6];
            pool[0] = CH_LPAR; pool[1] = CH_RPAR; pool[2] = CH_HASH;
            pool[3] = 8'h35;   pool[4] = 8'h51;   pool[5] = 8'($urandom);
            pos  = $urandom_range(0, s.len() - 1);
            junk = pool[$urandom_range(0, 5)];
            s[pos] = junk;
         end
         if ($urandom_range(0, 19) == 0) begin
            send_str(s.substr(0, 1), 0);
            idle($urandom_range(TMO - 2, TMO + 2));
            send_str(s.substr(2, s.len() - 1), 0);
         end else begin
            send_str(s, $urandom_range(0, 2));
         end
         if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 4));
      end
      idle(TMO + 2);

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
